// File: rtl/ram_bus_arbiter_if.sv
// Purpose: bundle of requestor-side and memory-write-side signals for ram_bus_arbiter.
// Signals:
//   iReq, iWriteEnable    per-requestor request and write strobe
//   iWriteAddress, iData  flattened per-requestor address/data slices (slice i = requestor i)
//   iForce, iForceIdx     owner override
//   oGrant, oOwner        one-hot owner and its index
//   oWriteEnable, oWriteAddress, oData  registered memory write port
//   oConflict             sticky non-owner write flag
// Modports: master (requestor/testbench side), slave (arbiter side).
interface ram_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 96,
    parameter int unsigned ADDR_W  = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        iReq;
    logic [NUM_REQ-1:0]        iWriteEnable;
    logic [NUM_REQ*ADDR_W-1:0] iWriteAddress;
    logic [NUM_REQ*DATA_W-1:0] iData;
    logic                      iForce;
    logic [IDX_W-1:0]          iForceIdx;
    logic [NUM_REQ-1:0]        oGrant;
    logic [IDX_W-1:0]          oOwner;
    logic                      oWriteEnable;
    logic [ADDR_W-1:0]         oWriteAddress;
    logic [DATA_W-1:0]         oData;
    logic                      oConflict;

    modport master (
        output iReq, iWriteEnable, iWriteAddress, iData, iForce, iForceIdx,
        input  oGrant, oOwner, oWriteEnable, oWriteAddress, oData, oConflict
    );

    modport slave (
        input  iReq, iWriteEnable, iWriteAddress, iData, iForce, iForceIdx,
        output oGrant, oOwner, oWriteEnable, oWriteAddress, oData, oConflict
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Purpose: arbitrates NUM_REQ write requestors onto a single registered RAM write port.
//   Round-robin with burst limit (RR_MODE=1) or fixed priority, index 0 highest (RR_MODE=0).
//   iForce imposes an owner. Non-owner write strobes are dropped and flagged in oConflict.
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    ram_bus_arbiter_if.slave (requests, write slices, force, grant, write port, conflict)
module ram_bus_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 96,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RR_MODE   = 1,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    ram_bus_arbiter_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 conflict_q, conflict_d;

    logic [NUM_REQ-1:0]   others;
    logic                 idle_found, oth_found;
    logic [IDX_W-1:0]     idle_idx, oth_idx;
    logic                 force_ok;

    // Winner search: first requester after ptr (wrapping, ptr last) or lowest index.
    function automatic void pick(input logic [NUM_REQ-1:0] req, input logic [IDX_W-1:0] ptr,
                                 output logic found, output logic [IDX_W-1:0] idx);
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            if (RR_MODE != 0) j = (32'(ptr) + k + 1) % NUM_REQ;
            else              j = k;
            if (!found && req[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    endfunction

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state: ownership, last-owner pointer and burst counter.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        others  = bus.iReq & ~grant_q;
        pick(bus.iReq, last_q, idle_found, idle_idx);
        pick(others, owner_q, oth_found, oth_idx);
        // An out-of-range force index (non power-of-two NUM_REQ) is ignored.
        force_ok = bus.iForce && (32'(bus.iForceIdx) < NUM_REQ);

        if (force_ok) begin
            state_d = OWNED;
            owner_d = bus.iForceIdx;
            last_d  = bus.iForceIdx;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_found) begin
                        state_d = OWNED;
                        owner_d = idle_idx;
                        last_d  = idle_idx;
                        cnt_d   = '0;
                    end
                end
                OWNED: begin
                    if (bus.iReq[owner_q]) begin
                        if ((RR_MODE != 0) && (cnt_q == CNT_W'(MAX_BURST - 1)) && oth_found) begin
                            owner_d = oth_idx;
                            last_d  = oth_idx;
                            cnt_d   = '0;
                        end else if (cnt_q < CNT_W'(MAX_BURST - 1)) begin
                            // Saturates at the limit so a lone owner never wraps the counter.
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (oth_found) begin
                        owner_d = oth_idx;
                        last_d  = oth_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output next-values: grant from new owner, write port from the current (old) owner.
    always_comb begin
        grant_d    = (state_d == OWNED) ? (NUM_REQ'(1) << owner_d) : '0;
        we_d       = |(bus.iWriteEnable & grant_q);
        addr_d     = addr_q;
        data_d     = data_q;
        if (we_d) begin
            addr_d = bus.iWriteAddress[32'(owner_q)*ADDR_W +: ADDR_W];
            data_d = bus.iData[32'(owner_q)*DATA_W +: DATA_W];
        end
        conflict_d = conflict_q | (|(bus.iWriteEnable & ~grant_q));
    end

    assign bus.oGrant        = grant_q;
    assign bus.oOwner        = owner_q;
    assign bus.oWriteEnable  = we_q;
    assign bus.oWriteAddress = addr_q;
    assign bus.oData         = data_q;
    assign bus.oConflict     = conflict_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Purpose: self-checking bench for ram_bus_arbiter; one round-robin and one fixed-priority
// instance. Expected outputs are queued when inputs are driven and compared after the edge.
module tb_ram_bus_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 96;
    localparam int unsigned AW = 16;
    localparam int unsigned MB = 8;

    typedef struct packed {
        logic        fp;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        we;
        logic [15:0] addr;
        logic [95:0] data;
        logic        conflict;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) rr_if ();
    ram_bus_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) fp_if ();

    ram_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1), .MAX_BURST(MB)) dut_rr (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (rr_if.slave)
    );

    ram_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0), .MAX_BURST(MB)) dut_fp (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (fp_if.slave)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic fp, input logic [3:0] g, input logic [1:0] o,
                                input logic we, input logic [15:0] a, input logic [95:0] d,
                                input logic c);
        exp_t e;
        e.fp = fp; e.grant = g; e.owner = o; e.we = we; e.addr = a; e.data = d; e.conflict = c;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        if (e.fp) begin
            check({tag, ".grant"}, 128'(fp_if.oGrant), 128'(e.grant));
            check({tag, ".owner"}, 128'(fp_if.oOwner), 128'(e.owner));
            check({tag, ".we"},    128'(fp_if.oWriteEnable), 128'(e.we));
            check({tag, ".conf"},  128'(fp_if.oConflict), 128'(e.conflict));
        end else begin
            check({tag, ".grant"}, 128'(rr_if.oGrant), 128'(e.grant));
            check({tag, ".owner"}, 128'(rr_if.oOwner), 128'(e.owner));
            check({tag, ".we"},    128'(rr_if.oWriteEnable), 128'(e.we));
            check({tag, ".addr"},  128'(rr_if.oWriteAddress), 128'(e.addr));
            check({tag, ".data"},  128'(rr_if.oData), 128'(e.data));
            check({tag, ".conf"},  128'(rr_if.oConflict), 128'(e.conflict));
        end
    endtask

    // Queue the expectation for the coming edge, then compare once the edge has passed.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 128'(0), 128'(1));
        end else begin
            got = exp_q.pop_front();
            compare(tag, got);
        end
    endtask

    task automatic set_slice(input int i, input logic [15:0] a, input logic [95:0] d);
        rr_if.iWriteAddress[i*AW +: AW] = a;
        rr_if.iData[i*DW +: DW]         = d;
    endtask

    initial begin
        logic [1:0] o;
        rst_n = 1'b0;
        rr_if.iReq = '0; rr_if.iWriteEnable = '0; rr_if.iWriteAddress = '0; rr_if.iData = '0;
        rr_if.iForce = 1'b0; rr_if.iForceIdx = '0;
        fp_if.iReq = '0; fp_if.iWriteEnable = '0; fp_if.iWriteAddress = '0; fp_if.iData = '0;
        fp_if.iForce = 1'b0; fp_if.iForceIdx = '0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_rr", mk(0, 4'b0000, 2'd0, 0, 16'h0, 96'h0, 0));
        compare("reset_fp", mk(1, 4'b0000, 2'd0, 0, 16'h0, 96'h0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed priority: lowest index wins, no preemption, no bubble on handover.
        fp_if.iReq = 4'b0110; step("fp_first", mk(1, 4'b0010, 2'd1, 0, 0, 0, 0));
        fp_if.iReq = 4'b0100; step("fp_handover", mk(1, 4'b0100, 2'd2, 0, 0, 0, 0));
        fp_if.iReq = 4'b0111;
        for (int i = 0; i < 10; i++) step("fp_hold", mk(1, 4'b0100, 2'd2, 0, 0, 0, 0));
        fp_if.iReq = 4'b0011; step("fp_lowest", mk(1, 4'b0001, 2'd0, 0, 0, 0, 0));
        fp_if.iReq = 4'b0000; step("fp_idle", mk(1, 4'b0000, 2'd0, 0, 0, 0, 0));

        // Round-robin rotation with 8-cycle bursts, starting from requestor 0.
        rr_if.iReq = 4'b1111;
        for (int n = 1; n <= 40; n++) begin
            o = 2'(((n - 1) / 8) % 4);
            step("rr_rotate", mk(0, 4'b0001 << o, o, 0, 0, 0, 0));
        end
        rr_if.iReq = 4'b0000; step("rr_idle", mk(0, 4'b0000, 2'd0, 0, 0, 0, 0));

        // Write pass-through for owner 2; other slices carry decoys.
        for (int i = 0; i < 4; i++) set_slice(i, 16'h1000 + 16'(i), {32'hDEAD, 32'h0, 32'h100 + 32'(i)});
        set_slice(2, 16'h0042, 96'hA5);
        rr_if.iReq = 4'b0100; step("wr_grant", mk(0, 4'b0100, 2'd2, 0, 16'h0, 96'h0, 0));
        rr_if.iWriteEnable = 4'b0100; step("wr_pass", mk(0, 4'b0100, 2'd2, 1, 16'h0042, 96'hA5, 0));
        rr_if.iWriteEnable = 4'b0000; set_slice(2, 16'h0099, 96'h99);
        step("wr_hold", mk(0, 4'b0100, 2'd2, 0, 16'h0042, 96'hA5, 0));

        // Grant-change edge still samples the old owner's write.
        set_slice(2, 16'h0043, 96'hB6);
        rr_if.iWriteEnable = 4'b0100; rr_if.iReq = 4'b0001;
        step("wr_change", mk(0, 4'b0001, 2'd0, 1, 16'h0043, 96'hB6, 0));
        set_slice(0, 16'h0007, 96'h77);
        rr_if.iWriteEnable = 4'b0001; step("wr_new", mk(0, 4'b0001, 2'd0, 1, 16'h0007, 96'h77, 0));

        // Non-owner strobe: dropped, conflict sticky.
        set_slice(3, 16'h0333, 96'h3333);
        rr_if.iWriteEnable = 4'b1000; step("conflict_set", mk(0, 4'b0001, 2'd0, 0, 16'h0007, 96'h77, 1));
        rr_if.iWriteEnable = 4'b0000;
        for (int i = 0; i < 3; i++) step("conflict_sticky", mk(0, 4'b0001, 2'd0, 0, 16'h0007, 96'h77, 1));

        // Force override during owner 1's burst, held past MAX_BURST.
        rr_if.iReq = 4'b0010; step("force_pre", mk(0, 4'b0010, 2'd1, 0, 16'h0007, 96'h77, 1));
        step("force_pre2", mk(0, 4'b0010, 2'd1, 0, 16'h0007, 96'h77, 1));
        rr_if.iForce = 1'b1; rr_if.iForceIdx = 2'd3;
        for (int i = 0; i < 9; i++) step("force_hold", mk(0, 4'b1000, 2'd3, 0, 16'h0007, 96'h77, 1));
        rr_if.iWriteEnable = 4'b1000;
        step("force_write", mk(0, 4'b1000, 2'd3, 1, 16'h0333, 96'h3333, 1));
        rr_if.iWriteEnable = 4'b0000; rr_if.iForce = 1'b0; rr_if.iReq = 4'b0011;
        step("force_release", mk(0, 4'b0001, 2'd0, 0, 16'h0333, 96'h3333, 1));
        step("force_after", mk(0, 4'b0001, 2'd0, 0, 16'h0333, 96'h3333, 1));

        // Reset mid-burst of owner 2.
        set_slice(2, 16'h0055, 96'h55);
        rr_if.iReq = 4'b0100; step("rst_pre", mk(0, 4'b0100, 2'd2, 0, 16'h0333, 96'h3333, 1));
        rr_if.iWriteEnable = 4'b0100; step("rst_wr", mk(0, 4'b0100, 2'd2, 1, 16'h0055, 96'h55, 1));
        #2 rst_n = 1'b0;
        #1 compare("rst_async", mk(0, 4'b0000, 2'd0, 0, 16'h0, 96'h0, 0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_if.iReq = 4'b1111; rr_if.iWriteEnable = 4'b0000;
        step("rst_restart", mk(0, 4'b0001, 2'd0, 0, 16'h0, 96'h0, 0));
        rr_if.iWriteEnable = 4'b0001;
        step("rst_write", mk(0, 4'b0001, 2'd0, 1, 16'h0007, 96'h77, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
